// File: rtl/adder_vector_player.sv
// adder_vector_player: plays a loadable table of full-adder vectors to a DUT and counts output mismatches.
// Optional ADDER_VP_STOP_ON_ERR_EN ends a run at the first mismatching vector.
module adder_vector_player #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [4:0]        wr_data,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              dut_a,
    output logic              dut_b,
    output logic              dut_cin,
    input  logic              dut_sum,
    input  logic              dut_cout,
    output logic [ADDR_W:0]   err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_idx
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRIVE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int CNT_W = $clog2(SETTLE) + 1;
    localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(DEPTH);
`ifdef ADDER_VP_STOP_ON_ERR_EN
    localparam logic STOP_ON_ERR = 1'b1;
`else
    localparam logic STOP_ON_ERR = 1'b0;
`endif

    logic [4:0]        mem_q [DEPTH];
    logic [4:0]        mem_d [DEPTH];
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_q, a_d, b_q, b_d, cin_q, cin_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic              fev_q, fev_d;
    logic [ADDR_W-1:0] fei_q, fei_d;
    logic [4:0]        vec;
    logic              mismatch, last, stop;

    assign busy            = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done            = done_q;
    assign dut_a           = a_q;
    assign dut_b           = b_q;
    assign dut_cin         = cin_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

    always_comb begin
        mem_d = mem_q;
        if (wr_en && !busy) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        done_d   = done_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fei_d    = fei_q;
        vec      = mem_q[idx_q];
        mismatch = {dut_sum, dut_cout} != vec[1:0];
        last     = {1'b0, idx_q} == n_q - 1'b1;
        stop     = last || (STOP_ON_ERR && mismatch);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d     = (num_vec > N_MAX) ? N_MAX : num_vec;
                    idx_d   = '0;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fei_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            // One accept cycle so a same-edge table write is visible to the first DRIVE.
            S_LOAD: begin
                state_d = (n_q == '0) ? S_DONE : S_DRIVE;
                done_d  = (n_q == '0);
            end
            S_DRIVE: begin
                {a_d, b_d, cin_d} = vec[4:2];
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(SETTLE - 1)) ? S_CHECK : S_WAIT;
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = (err_q == '1) ? err_q : err_q + 1'b1;
                    fev_d = 1'b1;
                    fei_d = fev_q ? fei_q : idx_q;
                end
                state_d = stop ? S_DONE : S_DRIVE;
                done_d  = stop;
                idx_d   = stop ? idx_q : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fei_q   <= fei_d;
        end
    end
endmodule
